data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
// - Responder (memory) end of the SoC core's load/store port: serves the core's write-enable/address/write-data requests and returns read data.
// - Word-organised synchronous RAM behind a valid/ready request channel and a valid/ready response channel.
// - One outstanding transaction; fixed, parameterised response latency. Sits between the core datapath and on-chip storage.
// PARAMETERS
// - XLEN         32    data/address width (32 or 64); lane count NB = XLEN/8
// - DEPTH_WORDS  1024  storage depth in XLEN-bit words; power of two
// - LATENCY      1     cycles from request accept to rsp_valid; legal 1..4 (elaboration error otherwise)
// PORTS
// - clk              in   1       single clock, rising edge
// - rst              in   1       reset; one clock; reset is synchronous and active-high
// - req_valid        in   1       request present
// - req_ready        out  1       responder can accept a request
// - req_write_enable in   1       1 = store, 0 = load
// - req_address      in   XLEN    byte address
// - req_write_data   in   XLEN    store data, lane i = bits [8i+7:8i]
// - req_byte_enable  in   NB      store lane mask; ignored for loads
// - rsp_valid        out  1       response present
// - rsp_ready        in   1       core accepts response
// - rsp_read_data    out  XLEN    load data; 0 for stores and errors
// - rsp_error        out  1       access faulted (range / alignment)
// BEHAVIOUR
// - Reset (rst high at an edge): state IDLE, req_ready=1, rsp_valid=0, rsp_read_data=0, rsp_error=0, latency counter=0. RAM contents not reset.
// - Accept: request accepted on the edge where req_valid && req_ready. All req_* fields are sampled only at that edge.
// - FSM:
//   - IDLE -> WAIT on accept; req_ready=0 in every state except IDLE.
//   - WAIT: counter counts LATENCY-1 cycles, then -> RESP. For LATENCY=1, IDLE -> RESP directly.
//   - RESP: rsp_valid=1. Go to IDLE on the edge where rsp_valid && rsp_ready.
//   - Accept at edge T gives rsp_valid high from T+LATENCY.
//   - req_ready returns high the cycle after response handshake; no same-cycle turnaround.
//   - rsp_read_data/rsp_error are stable while rsp_valid=1 && !rsp_ready; rsp_valid never drops without handshake.
//   - rsp_ready is ignored outside RESP.
// - Addressing: word index = req_address[log2(NB) +: log2(DEPTH_WORDS)].
// - Range error: any set address bit above the index field gives error=1, no RAM access, data 0.
// - Store: at the accept edge, write only lanes with byte_enable[i]=1. byte_enable=0 is a legal no-op store with error=0.
// - Load: full word read at the accept edge into a response register, so a load returns memory as of acceptance.
// - Simultaneous: req_valid while not IDLE is ignored (held by core). rst has priority over every handshake.
// - Reset mid-operation: pending response is discarded, never presented. A store committed at its accept edge stays written.
// CONFIGURATION
// - DATA_MEMORY_MISALIGN_TRAP_EN defined:
//   - address[log2(NB)-1:0] != 0 gives rsp_error=1, rsp_read_data=0, no RAM write.
//   - Same latency as a normal access.
// - DATA_MEMORY_MISALIGN_TRAP_EN undefined:
//   - low address bits are ignored; access proceeds on the containing aligned word.
//   - rsp_error reflects only range errors.
// TESTING (XLEN=32, DEPTH_WORDS=1024, LATENCY=2 unless noted)
// - Store 0xDEADBEEF @0x10, be=4'hF, then load @0x10 -> rsp_valid 2 cycles after each accept; load data 0xDEADBEEF, error 0; store data 0.
// - Store 0x000000AA @0x10, be=4'b0001 over 0xDEADBEEF -> load returns 0xDEADBEAA.
// - Load @0x1000 (beyond 4 KiB) -> rsp_error=1, data 0; word 0 unchanged.
// - Load @0x12: macro defined -> error=1, data 0; undefined -> data of word 0x10, error 0.
// - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0; req_ready=1 one cycle after handshake.
// - Assert rst while in WAIT after store 0x12345678 @0x20 -> next cycle rsp_valid=0, req_ready=1; load @0x20 returns 0x12345678.

Source files
------------

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Memory end of the core's load/store port. A word-organised RAM is reached
// through a valid/ready request channel and answered through a valid/ready
// response channel. Only one transaction is in flight at a time, and the
// response latency is fixed by the LATENCY parameter.
//
// Handshake rule (both channels): a transfer happens on the rising edge where
// valid && ready are both high. The sender holds valid and its payload stable
// until that edge. The responder holds rsp_valid, rsp_read_data and rsp_error
// stable until the response is taken, and never drops rsp_valid before then.
//
// Parameters
//   XLEN         data/address width (32 or 64); NB = XLEN/8 byte lanes
//   DEPTH_WORDS  storage depth in XLEN-bit words (power of two)
//   LATENCY      request accept edge to first rsp_valid cycle, 1..4
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   req_valid/ready   request handshake (req_ready is high only when idle)
//   req_write_enable  1 = store, 0 = load
//   req_address       byte address
//   req_write_data    store data, lane i = bits [8i+7:8i]
//   req_byte_enable   store lane mask (ignored for loads)
//   rsp_valid/ready   response handshake
//   rsp_read_data     load data; 0 for stores and faulted accesses
//   rsp_error         access faulted (address out of range, or misaligned
//                     when the trap below is enabled)
//
// Configuration macro
//   DATA_MEMORY_MISALIGN_TRAP_EN  when defined, a non-zero byte offset in the
//                                 address faults the access. When undefined,
//                                 the offset is ignored and the containing
//                                 aligned word is used.
//
// The FSM state is available as state_q (type state_t) for checkers.
// -----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write_enable,
    input  logic [XLEN-1:0]   req_address,
    input  logic [XLEN-1:0]   req_write_data,
    input  logic [XLEN/8-1:0] req_byte_enable,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_read_data,
    output logic              rsp_error
);

    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH_WORDS);
    localparam int TOP = OFF + IW;

    // WAIT lasts LATENCY-1 cycles; the counter runs 0 .. LATENCY-2.
    localparam logic [1:0] CNT_LAST = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("data_memory_responder: LATENCY must be in 1..4");
        end
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("data_memory_responder: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_read_data_q, rsp_read_data_d;
    logic              rsp_error_q, rsp_error_d;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic [IW-1:0]     word_idx;
    logic              range_err;
    logic              misalign_err;
    logic              access_err;
    logic              accept;
    logic              mem_we;

    assign word_idx  = req_address[OFF +: IW];
    // Any address bit above the word-index field is outside the array.
    assign range_err = (req_address >> TOP) != '0;

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    assign misalign_err = req_address[OFF-1:0] != '0;
`else
    assign misalign_err = 1'b0;
`endif

    assign access_err = range_err || misalign_err;

    // Reset wins over the request handshake, so nothing is accepted (or
    // written) on a reset edge.
    assign accept = req_valid && req_ready_q && !rst;
    assign mem_we = accept && req_write_enable && !access_err;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        req_ready_d     = req_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_read_data_d = rsp_read_data_q;
        rsp_error_d     = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_error_d = access_err;
                    // Load data is captured at acceptance, so the response
                    // reflects memory as it was at that edge.
                    rsp_read_data_d = (!req_write_enable && !access_err) ? mem[word_idx] : '0;
                    cnt_d = 2'd0;
                    if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = 2'(cnt_q + 2'd1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d         = ST_IDLE;
                    rsp_valid_d     = 1'b0;
                    req_ready_d     = 1'b1;
                    rsp_read_data_d = '0;
                    rsp_error_d     = 1'b0;
                end
            end
            default: begin
                state_d         = ST_IDLE;
                cnt_d           = 2'd0;
                req_ready_d     = 1'b1;
                rsp_valid_d     = 1'b0;
                rsp_read_data_d = '0;
                rsp_error_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 2'd0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_read_data_q <= '0;
            rsp_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_read_data_q <= rsp_read_data_d;
            rsp_error_q     <= rsp_error_d;
        end
    end

    // Storage is not reset. Only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (req_byte_enable[i]) begin
                    mem[word_idx][8*i +: 8] <= req_write_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_read_data_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// Bench for data_memory_responder (XLEN=32, DEPTH_WORDS=1024, LATENCY=2).
// A reference model of the memory and of the channel timing is updated on
// every falling edge and compared with the DUT outputs. Directed sequences
// add literal expectations on top of that.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write_enable;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [3:0]  req_byte_enable;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_read_data;
  logic        rsp_error;

  data_memory_responder #(
    .XLEN(32),
    .DEPTH_WORDS(1024),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write_enable(req_write_enable),
    .req_address(req_address),
    .req_write_data(req_write_data),
    .req_byte_enable(req_byte_enable),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data),
    .rsp_error(rsp_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters and model state ----------------
  int total = 0;
  int bad = 0;

  logic [31:0] model_mem [0:1023];
  logic [32:0] exp_q[$];          // {error, data} per outstanding response
  bit          busy = 1'b0;       // a request has been accepted and not answered
  int          age = 0;           // cycles since the accept edge
  bit          mon_en = 1'b0;
  int          rsp_count = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;
  int          rdy_mode = 0;      // 0 random, 1 hold low, 2 hold high
  logic        exp_v;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Result of one access under the memory rules; updates the model memory.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] be);
    logic       range_e;
    logic       mis_e;
    logic [9:0] idx;
    range_e = addr[31:12] != 20'd0;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    mis_e = addr[1:0] != 2'd0;
`else
    mis_e = 1'b0;
`endif
    if (range_e || mis_e) return {1'b1, 32'h0};
    idx = addr[11:2];
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end
      return {1'b0, 32'h0};
    end
    return {1'b0, model_mem[idx]};
  endfunction

  // ---------------- response-ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) rsp_ready = 1'($urandom_range(0, 1));
    else rsp_ready = (rdy_mode == 2);
  end

  // ---------------- compare process ----------------
  // Outputs after edge N are checked at the following falling edge. The model
  // then advances using the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_v = busy && (age >= LATENCY);
      chk("req_ready", {63'd0, req_ready}, {63'd0, !busy});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      if (exp_v && exp_q.size() > 0) begin
        chk("rsp_read_data", {32'd0, rsp_read_data}, {32'd0, exp_q[0][31:0]});
        chk("rsp_error", {63'd0, rsp_error}, {63'd0, exp_q[0][32]});
      end
      if (rst) begin
        busy = 1'b0;
        age = 0;
        exp_q.delete();
      end else if (!busy) begin
        if (req_valid) begin
          exp_q.push_back(model_access(req_write_enable, req_address, req_write_data, req_byte_enable));
          busy = 1'b1;
          age = 1;
        end
      end else if (exp_v && rsp_ready) begin
        last_data = rsp_read_data;
        last_err = rsp_error;
        void'(exp_q.pop_front());
        busy = 1'b0;
        rsp_count++;
      end else begin
        age++;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input bit wait_rsp,
                     output logic [31:0] data, output logic err, output int lat);
    int n;
    int start;
    data = '0;
    err = 1'b0;
    lat = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write_enable = we;
    req_address = addr;
    req_write_data = wdata;
    req_byte_enable = be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write_enable = 1'($urandom_range(0, 1));
    req_address = $urandom;
    req_write_data = $urandom;
    req_byte_enable = 4'($urandom);
    if (wait_rsp) begin
      start = rsp_count;
      n = 0;
      while (rsp_count == start && n < 60) begin
        @(negedge clk);
        #1;
        n++;
        if (lat == 0 && rsp_valid) lat = n;
      end
      if (rsp_count == start) chk("rsp_timeout", 64'd0, 64'd1);
      data = last_data;
      err = last_err;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] d;
  logic        e;
  int          l;
  int          n;
  int          start;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write_enable = 1'b0;
    req_address = '0;
    req_write_data = '0;
    req_byte_enable = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_data", {32'd0, rsp_read_data}, 64'd0);
    chk("reset_rsp_error", {63'd0, rsp_error}, 64'd0);

    // Give the first 64 words known contents.
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) begin
      txn(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, d, e, l);
    end

    rdy_mode = 2;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, d, e, l);
    chk("store_data", {32'd0, d}, 64'd0);
    chk("store_err", {63'd0, e}, 64'd0);
    chk("store_latency", 64'(l), 64'd2);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, d, e, l);
    chk("load_data", {32'd0, d}, 64'hDEADBEEF);
    chk("load_err", {63'd0, e}, 64'd0);
    chk("load_latency", 64'(l), 64'd2);

    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b1, d, e, l);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, d, e, l);
    chk("partial_store", {32'd0, d}, 64'hDEADBEAA);

    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, d, e, l);
    chk("noop_store_err", {63'd0, e}, 64'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, d, e, l);
    chk("noop_store_keeps", {32'd0, d}, 64'hDEADBEAA);

    txn(1'b1, 32'h0, 32'h01020304, 4'hF, 1'b1, d, e, l);
    txn(1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, d, e, l);
    chk("range_err", {63'd0, e}, 64'd1);
    chk("range_data", {32'd0, d}, 64'd0);
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b1, d, e, l);
    chk("range_store_err", {63'd0, e}, 64'd1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, d, e, l);
    chk("word0_unchanged", {32'd0, d}, 64'h01020304);

    txn(1'b0, 32'h12, 32'h0, 4'h0, 1'b1, d, e, l);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    chk("misalign_err", {63'd0, e}, 64'd1);
    chk("misalign_data", {32'd0, d}, 64'd0);
`else
    chk("misalign_err", {63'd0, e}, 64'd0);
    chk("misalign_data", {32'd0, d}, 64'hDEADBEAA);
`endif

    // Response held off for five cycles.
    rdy_mode = 1;
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, d, e, l);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_valid_seen", {63'd0, rsp_valid}, 64'd1);
    repeat (5) begin
      chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall_data", {32'd0, rsp_read_data}, 64'hDEADBEAA);
      chk("stall_err", {63'd0, rsp_error}, 64'd0);
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      #1;
    end
    start = rsp_count;
    rdy_mode = 2;
    n = 0;
    while (rsp_count == start && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_handshake_seen", 64'(rsp_count - start), 64'd1);
    chk("no_turnaround", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    #1;
    chk("ready_after_hs", {63'd0, req_ready}, 64'd1);
    chk("valid_after_hs", {63'd0, rsp_valid}, 64'd0);

    // Reset while waiting on a store.
    txn(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, d, e, l);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, d, e, l);
    chk("midrst_store_kept", {32'd0, d}, 64'h12345678);
    chk("midrst_err", {63'd0, e}, 64'd0);

    // Randomized traffic over the initialized words plus out-of-range hits.
    rdy_mode = 0;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] addr;
      addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), 1'b1, d, e, l);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    rdy_mode = 2;
    repeat (10) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
